cache_line_axi_bridge: RTL

- Sits directly downstream of the cache's line-granular AXI_Bus_Interface (the slave modport) and drives an AXI4 master port toward the SoC interconnect.
- Converts one line refill request into one INCR read burst, and one dirty-line writeback into one INCR write burst.
- Read and write engines are independent, so a refill and a writeback may be in flight together.

---
 rtl/cache_axi_pkg.sv | 22 ++
 rtl/cache_line_axi_bridge_if.sv | 64 ++++++
 rtl/cache_line_axi_bridge_writer.sv | 113 +++++++++++
 rtl/cache_line_axi_bridge.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/cache_axi_pkg.sv
// rtl/cache_axi_pkg.sv - shared AXI constants, FSM state types and line type for the cache line bridge
package cache_axi_pkg;

  localparam int DCACHE_LINE_WORD = 4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_DONE} rd_state_t;
  typedef enum logic [2:0] {W_IDLE, W_AW, W_DATA, W_RESP, W_DONE} wr_state_t;

  typedef logic [DCACHE_LINE_WORD*32-1:0] line_t;

  // Clear the byte-offset-within-line bits of an address.
  function automatic logic [31:0] line_align(input logic [31:0] addr, input int unsigned words);
    logic [31:0] mask;
    mask = 32'(words * 4) - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/cache_line_axi_bridge_if.sv
// rtl/cache_line_axi_bridge_if.sv - AXI4 master-side bus bundle between the bridge and the interconnect
interface cache_line_axi_bridge_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/cache_line_axi_bridge_writer.sv
// rtl/cache_line_axi_bridge_writer.sv - axi_line_writer: victim line latch, write FSM and W beat mux
module axi_line_writer
  import cache_axi_pkg::*;
#(
  parameter int         LINE_WORD = DCACHE_LINE_WORD,
  parameter logic [3:0] AXI_ID    = 4'd1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_req,
  input  logic [31:0]            wr_addr,
  input  logic [LINE_WORD*32-1:0] wr_data,
  output logic                   wr_rdy,
  output logic                   wr_valid,
  output logic                   wr_busy,
  output logic [31:0]            wr_line_addr,
  output logic [3:0]             awid,
  output logic [31:0]            awaddr,
  output logic [7:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [31:0]            wdata,
  output logic [3:0]             wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic                   bvalid,
  output logic                   bready
);

  localparam int            CW        = $clog2(LINE_WORD);
  localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORD - 1);

  wr_state_t               state_q, state_d;
  logic [31:0]             addr_q, addr_d;
  logic [LINE_WORD*32-1:0] line_q, line_d;
  logic [CW-1:0]           beat_q, beat_d;

  // Write engine state, latched address, victim line and beat index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= W_IDLE;
      addr_q  <= '0;
      line_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
    end
  end

  // Write sequencing: AW first, then beats gated by wready, then wait for B.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    line_d   = line_q;
    beat_d   = beat_q;
    wr_rdy   = 1'b0;
    wr_valid = 1'b0;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    wlast    = 1'b0;
    bready   = 1'b0;
    case (state_q)
      W_IDLE: begin
        wr_rdy = 1'b1;
        if (wr_req) begin
          addr_d  = line_align(wr_addr, LINE_WORD);
          line_d  = wr_data;
          beat_d  = '0;
          state_d = W_AW;
        end
      end
      W_AW: begin
        awvalid = 1'b1;
        if (awready) state_d = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        wlast  = (beat_q == LAST_BEAT);
        if (wready) begin
          if (beat_q == LAST_BEAT) state_d = W_RESP;
          else                     beat_d  = beat_q + 1'b1;
        end
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) state_d = W_DONE;
      end
      W_DONE: begin
        wr_valid = 1'b1;
        state_d  = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  // Burst shape fields are only meaningful alongside awvalid/wvalid, so they read 0 otherwise.
  assign awid         = AXI_ID;
  assign awaddr       = addr_q;
  assign awlen        = awvalid ? 8'(LINE_WORD - 1) : 8'd0;
  assign awsize       = awvalid ? AXI_SIZE_WORD : 3'd0;
  assign awburst      = awvalid ? AXI_BURST_INCR : 2'd0;
  assign wdata        = line_q[{beat_q, 5'b0} +: 32];
  assign wstrb        = wvalid ? 4'hF : 4'h0;
  assign wr_busy      = (state_q != W_IDLE);
  assign wr_line_addr = addr_q;

endmodule

// File: rtl/cache_line_axi_bridge.sv
// rtl/cache_line_axi_bridge.sv - cache line refill/writeback to AXI4 INCR bursts; option CACHE_LINE_AXI_BRIDGE_RAW_BLOCK_EN
module cache_line_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter int         LINE_WORD = DCACHE_LINE_WORD,
  parameter logic [3:0] AXI_ID    = 4'd1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_req,
  input  logic [31:0]             rd_addr,
  output logic                    rd_rdy,
  output logic                    ret_valid,
  output logic [LINE_WORD*32-1:0] ret_data,
  input  logic                    wr_req,
  input  logic [31:0]             wr_addr,
  input  logic [LINE_WORD*32-1:0] wr_data,
  output logic                    wr_rdy,
  output logic                    wr_valid,
  cache_line_axi_bridge_if.master axi
);

  localparam int            CW        = $clog2(LINE_WORD);
  localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORD - 1);

  rd_state_t               rstate_q, rstate_d;
  logic [31:0]             raddr_q, raddr_d;
  logic [LINE_WORD*32-1:0] rbuf_q, rbuf_d;
  logic [CW-1:0]           rbeat_q, rbeat_d;
  logic                    arvalid, rready, raw_block;
  logic                    wr_busy;
  logic [31:0]             wr_line_addr;

`ifdef CACHE_LINE_AXI_BRIDGE_RAW_BLOCK_EN
  // Hold off a refill of the line currently being written back until its B response.
  assign raw_block = wr_busy && rd_req && (line_align(rd_addr, LINE_WORD) == wr_line_addr);
`else
  assign raw_block = 1'b0;
  logic unused_raw;
  assign unused_raw = ^{wr_busy, wr_line_addr};
`endif

  // Response codes and IDs are not acted on; data is delivered regardless.
  logic unused_resp;
  assign unused_resp = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};

  // Read engine state, latched address, line buffer and beat index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q <= R_IDLE;
      raddr_q  <= '0;
      rbuf_q   <= '0;
      rbeat_q  <= '0;
    end else begin
      rstate_q <= rstate_d;
      raddr_q  <= raddr_d;
      rbuf_q   <= rbuf_d;
      rbeat_q  <= rbeat_d;
    end
  end

  // Read sequencing: AR, collect beats into the line buffer, one-cycle return pulse.
  always_comb begin
    rstate_d  = rstate_q;
    raddr_d   = raddr_q;
    rbuf_d    = rbuf_q;
    rbeat_d   = rbeat_q;
    rd_rdy    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ret_valid = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        rd_rdy = !raw_block;
        if (rd_req && !raw_block) begin
          raddr_d  = line_align(rd_addr, LINE_WORD);
          rstate_d = R_AR;
        end
      end
      R_AR: begin
        arvalid = 1'b1;
        if (axi.arready) begin
          rbeat_d  = '0;
          rstate_d = R_DATA;
        end
      end
      R_DATA: begin
        rready = 1'b1;
        if (axi.rvalid) begin
          rbuf_d[{rbeat_q, 5'b0} +: 32] = axi.rdata;
          // A missing rlast must not let the counter run past the last word.
          if (axi.rlast || rbeat_q == LAST_BEAT) rstate_d = R_DONE;
          else                                   rbeat_d  = rbeat_q + 1'b1;
        end
      end
      R_DONE: begin
        ret_valid = 1'b1;
        rstate_d  = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  assign ret_data    = rbuf_q;
  assign axi.arid    = AXI_ID;
  assign axi.araddr  = raddr_q;
  assign axi.arlen   = arvalid ? 8'(LINE_WORD - 1) : 8'd0;
  assign axi.arsize  = arvalid ? AXI_SIZE_WORD : 3'd0;
  assign axi.arburst = arvalid ? AXI_BURST_INCR : 2'd0;
  assign axi.arvalid = arvalid;
  assign axi.rready  = rready;

  axi_line_writer #(
    .LINE_WORD (LINE_WORD),
    .AXI_ID    (AXI_ID)
  ) u_writer (
    .clk          (clk),
    .rst          (rst),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_rdy       (wr_rdy),
    .wr_valid     (wr_valid),
    .wr_busy      (wr_busy),
    .wr_line_addr (wr_line_addr),
    .awid         (axi.awid),
    .awaddr       (axi.awaddr),
    .awlen        (axi.awlen),
    .awsize       (axi.awsize),
    .awburst      (axi.awburst),
    .awvalid      (axi.awvalid),
    .awready      (axi.awready),
    .wdata        (axi.wdata),
    .wstrb        (axi.wstrb),
    .wlast        (axi.wlast),
    .wvalid       (axi.wvalid),
    .wready       (axi.wready),
    .bvalid       (axi.bvalid),
    .bready       (axi.bready)
  );

endmodule
